// File: rtl/search_pkg.sv
// search_pkg: shared state encoding and default sizes for the RAM search controller.
package search_pkg;
    localparam int SEARCH_ADDR_W = 5;
    localparam int SEARCH_DATA_W = 3;
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_e;
endpackage

// File: rtl/search_cmp.sv
// search_cmp: tags each RAM read with the address that produced it and flags a key match.
module search_cmp
    import search_pkg::*;
#(
    parameter int ADDR_W = SEARCH_ADDR_W,
    parameter int DATA_W = SEARCH_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] key_i,
    input  logic [DATA_W-1:0] ram_q_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] tag_o
);
    logic              vld_q;
    logic [ADDR_W-1:0] tag_q;
    // The tag lags the address by the RAM's one-cycle read latency, so it lines up with ram_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            tag_q <= '0;
        end else begin
            vld_q <= issue_i;
            tag_q <= addr_i;
        end
    end
    assign hit_o = vld_q && (ram_q_i == key_i);
    assign tag_o = tag_q;
endmodule

// File: rtl/search_ctrl.sv
// search_ctrl: scans a synchronous RAM for the lowest address holding a key.
// Define SEARCH_COUNT_EN to scan every address and count all matches in match_cnt.
module search_ctrl
    import search_pkg::*;
#(
    parameter int ADDR_W = SEARCH_ADDR_W,
    parameter int DATA_W = SEARCH_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] ram_q,
    output logic              rw,
    output logic              sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              miss,
`ifdef SEARCH_COUNT_EN
    output logic [ADDR_W:0]   match_cnt,
`endif
    output logic [ADDR_W-1:0] found_addr
);
    localparam logic [ADDR_W-1:0] LAST = '1;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, found_addr_q, found_addr_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              found_q, found_d, miss_q, miss_d;
    logic              hit;
    logic [ADDR_W-1:0] tag;
`ifdef SEARCH_COUNT_EN
    logic [ADDR_W:0]   cnt_q, cnt_d;
`endif

    search_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp (
        .clk     (clk),
        .reset   (reset),
        .issue_i (state_q == SCAN),
        .addr_i  (rd_addr_q),
        .key_i   (key_q),
        .ram_q_i (ram_q),
        .hit_o   (hit),
        .tag_o   (tag)
    );

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        key_d        = key_q;
        found_d      = found_q;
        miss_d       = miss_q;
        found_addr_d = found_addr_q;
`ifdef SEARCH_COUNT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d      = SCAN;
                key_d        = key;
                rd_addr_d    = '0;
                found_d      = 1'b0;
                miss_d       = 1'b0;
                found_addr_d = '0;
`ifdef SEARCH_COUNT_EN
                cnt_d        = '0;
`endif
            end
            SCAN, FLUSH: begin
                if (state_q == FLUSH) state_d = DONE;
                else if (rd_addr_q == LAST) state_d = FLUSH;
                else rd_addr_d = rd_addr_q + 1'b1;
                if (hit && !found_q) begin
                    found_d      = 1'b1;
                    found_addr_d = tag;
                end
`ifdef SEARCH_COUNT_EN
                if (hit) cnt_d = cnt_q + 1'b1;
`else
                if (hit) state_d = DONE;
`endif
                if (state_d == DONE) miss_d = !found_d;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            key_q        <= '0;
            found_q      <= 1'b0;
            miss_q       <= 1'b0;
            found_addr_q <= '0;
`ifdef SEARCH_COUNT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            key_q        <= key_d;
            found_q      <= found_d;
            miss_q       <= miss_d;
            found_addr_q <= found_addr_d;
`ifdef SEARCH_COUNT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign sel        = (state_q == SCAN) || (state_q == FLUSH);
    assign rw         = wr_req && !busy;
    assign rd_addr    = rd_addr_q;
    assign found      = found_q;
    assign miss       = miss_q;
    assign found_addr = found_addr_q;
`ifdef SEARCH_COUNT_EN
    assign match_cnt  = cnt_q;
`endif
endmodule

// File: doc/search_ctrl.md
SEARCH_CTRL -- requirements
Module: search_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width (depth 2^ADDR_W).
REQ-002 Parameter DATA_W, default 3, RAM word and search key width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a search; sampled only in IDLE.
REQ-006 key  input  DATA_W  search key; captured on accepted start.
REQ-007 wr_req  input  1  host write request for RAM.
REQ-008 ram_q  input  DATA_W  RAM read data; valid one cycle after rd_addr is presented.
REQ-009 rw  output  1  RAM write enable, equal to wr_req AND NOT busy.
REQ-010 sel  output  1  address-mux select: 1 selects rd_addr, 0 selects host address.
REQ-011 rd_addr  output  ADDR_W  RAM read address during scan.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse at search end.
REQ-014 found  output  1  match result, held until next accepted start.
REQ-015 miss  output  1  NOT found once a search has completed, held until next accepted start.
REQ-016 found_addr  output  ADDR_W  lowest matching address, held until next accepted start.

Function
REQ-017 States SHALL be IDLE, SCAN, FLUSH, DONE.
REQ-018 IDLE: start=1 SHALL capture key, set rd_addr=0, clear found/miss/found_addr, and go to SCAN.
REQ-019 SCAN: rd_addr SHALL increment by 1 per cycle; a compare pipeline SHALL tag each ram_q with its address, delayed one cycle.
REQ-020 A compare hit (ram_q == captured key) at tagged address a SHALL go to DONE with found=1 and found_addr=a; further compares are discarded.
REQ-021 When rd_addr reaches 2^ADDR_W-1, SCAN SHALL go to FLUSH; rd_addr SHALL NOT wrap.
REQ-022 FLUSH SHALL compare the final address; hit per REQ-020, otherwise DONE with found=0.
REQ-023 DONE SHALL last one cycle with done=1 and miss=~found, then return to IDLE.
REQ-024 Latency: a start accepted at edge 0 with first hit at address a SHALL assert done in the cycle after edge a+2; a full miss SHALL assert done after edge 2^ADDR_W+1.
REQ-025 start outside IDLE SHALL be ignored; key changes after capture SHALL have no effect.
REQ-026 sel SHALL be 1 in SCAN and FLUSH, 0 otherwise; rw SHALL be 0 whenever busy=1.

Reset
REQ-027 reset SHALL force IDLE, rd_addr=0, busy=0, done=0, found=0, miss=0, found_addr=0, and match_cnt=0 when present; reset mid-search SHALL abandon the search without a done pulse.

Configuration
REQ-028 With SEARCH_COUNT_EN defined: output match_cnt (ADDR_W+1 bits); a hit SHALL NOT end the scan, all addresses are compared, match_cnt counts hits, and found_addr is the lowest hit; done always follows 2^ADDR_W+1 edges after start.
REQ-029 Without SEARCH_COUNT_EN: no match_cnt port; first-hit early termination per REQ-020.

Structure
REQ-030 Shared package search_pkg SHALL hold the state enum and the default ADDR_W/DATA_W constants.
REQ-031 One sub-module, search_cmp (registered equality compare with address tag), is natural; the FSM stays in search_ctrl.

Verification
REQ-032 RAM filled 0..31 with data=addr%8, key=5, start -> done after edge 7, found=1, found_addr=5.
REQ-033 All words 3, key=6 -> done after edge 33, found=0, miss=1, rd_addr stops at 31.
REQ-034 Only word 31 = 2, key=2 -> found=1, found_addr=31 (FLUSH path).
REQ-035 start pulsed again and wr_req=1 during busy -> ignored, rw=0, result unchanged.
REQ-036 reset asserted at SCAN address 10 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-037 SEARCH_COUNT_EN, key=5 with data=addr%8 -> match_cnt=4, found_addr=5, done after edge 33.
